// File: rtl/bram_tile_reader.sv
// Drains a strided result tile from BRAM Port B and streams it over valid/ready.
// Define BRAM_DOUT_REG_EN when the BRAM output register is enabled (two-cycle read latency).
module bram_tile_reader #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned STRIDE = 24,
    parameter int unsigned INNER  = 1536,
    parameter int unsigned OUTER  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_read,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              read_done,
    output logic [ADDR_W-1:0] current_addr
);

`ifdef BRAM_DOUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif
    localparam int unsigned DEPTH = LAT + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned CR_W  = CNT_W + 1;
    localparam int unsigned IN_W  = $clog2(INNER + 1);
    localparam int unsigned OUT_W = $clog2(OUTER + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IN_W-1:0]    inner_q, inner_d;
    logic [OUT_W-1:0]   outer_q, outer_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0]  cur_q, cur_d;
    logic [LAT-1:0]     pipe_q, pipe_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               push, pop, fifo_empty, wr_en, rd_adv, last_issue;
    logic [CNT_W-1:0]   inflight;
    logic [CR_W-1:0]    credit_used;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_q[i]);
        end
    end

    // Returned words may bypass an empty FIFO so the first word is visible on arrival.
    assign push        = pipe_q[LAT-1];
    assign fifo_empty  = (count_q == '0);
    assign m_valid     = !fifo_empty || push;
    assign m_data      = (fifo_empty && push) ? bram_dout : mem_q[rd_ptr_q];
    assign pop         = m_valid && m_ready;
    assign credit_used = CR_W'(count_q) + CR_W'(inflight) - CR_W'(pop);
    assign last_issue  = (inner_q == IN_W'(INNER - 1)) && (outer_q == OUT_W'(OUTER - 1));

    assign bram_en      = (state_q == StIssue) && (credit_used < CR_W'(DEPTH));
    assign bram_addr    = addr_q;
    assign current_addr = cur_q;
    assign busy         = busy_q;
    assign read_done    = done_q;

    always_comb begin
        pipe_d[0] = bram_en;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        wr_en    = push && !(pop && fifo_empty);
        rd_adv   = pop && !fifo_empty;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_adv) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // Address walks base + inner*STRIDE + outer by accumulation; col_q holds base + outer.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        inner_d = inner_q;
        outer_d = outer_q;
        addr_d  = addr_q;
        col_d   = col_q;
        cur_d   = cur_q;
        unique case (state_q)
            StIdle: begin
                if (start_read) begin
                    state_d = StIssue;
                    busy_d  = 1'b1;
                    inner_d = '0;
                    outer_d = '0;
                    addr_d  = base_addr;
                    col_d   = base_addr;
                end
            end
            StIssue: begin
                if (bram_en) begin
                    cur_d = addr_q;
                    if (inner_q == IN_W'(INNER - 1)) begin
                        inner_d = '0;
                        outer_d = outer_q + 1'b1;
                        col_d   = col_q + 1'b1;
                        addr_d  = col_q + 1'b1;
                        if (last_issue) begin
                            state_d = StDrain;
                        end
                    end else begin
                        inner_d = inner_q + 1'b1;
                        addr_d  = addr_q + ADDR_W'(STRIDE);
                    end
                end
            end
            StDrain: begin
                if ((inflight == '0) && fifo_empty && !pop) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            inner_q  <= '0;
            outer_q  <= '0;
            addr_q   <= '0;
            col_q    <= '0;
            cur_q    <= '0;
            pipe_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            inner_q  <= inner_d;
            outer_q  <= outer_d;
            addr_q   <= addr_d;
            col_q    <= col_d;
            cur_q    <= cur_d;
            pipe_q   <= pipe_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= bram_dout;
            end
        end
    end

    // The credit rule guarantees a free slot for every returning word.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !rd_adv && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_bram_tile_reader.sv
// Directed bench for bram_tile_reader with a small tile (INNER=4, OUTER=3, STRIDE=24).
module tb_bram_tile_reader;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned STRIDE = 24;
    localparam int unsigned INNER  = 4;
    localparam int unsigned OUTER  = 3;
    localparam int unsigned TOTAL  = INNER * OUTER;
`ifdef BRAM_DOUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = LAT + 1;

    logic              clk, rst_n, start_read, bram_en, m_valid, m_ready, busy, read_done;
    logic [ADDR_W-1:0] base_addr, bram_addr, current_addr;
    logic [DATA_W-1:0] bram_dout, m_data;
    logic [DATA_W-1:0] rd1;

    int checks = 0;
    int errors = 0;

    bram_tile_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRIDE(STRIDE), .INNER(INNER), .OUTER(OUTER)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_read(start_read), .base_addr(base_addr),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .read_done(read_done), .current_addr(current_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: word(a) = a + 2.
    always @(posedge clk) if (bram_en) rd1 <= DATA_W'(bram_addr) + DATA_W'(2);
`ifdef BRAM_DOUT_REG_EN
    logic [DATA_W-1:0] rd2;
    always @(posedge clk) rd2 <= rd1;
    assign bram_dout = rd2;
`else
    assign bram_dout = rd1;
`endif

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] base, input int k);
        return base + ADDR_W'((k % INNER) * STRIDE) + ADDR_W'(k / INNER);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, bram_en, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, read_done, 0);
        chk({tag, "_baddr"}, bram_addr, 0);
        chk({tag, "_caddr"}, current_addr, 0);
        chk({tag, "_data"}, m_data, 0);
    endtask

    // bp: ready pattern 1,0,0,1; ign_at: cycle of an ignored start; abort_after: reset after N words.
    task automatic run_tile(input logic [ADDR_W-1:0] base, input bit bp, input int ign_at,
                            input int abort_after, output logic [ADDR_W-1:0] a0,
                            output logic [ADDR_W-1:0] a1);
        int issued, popped, first_pop, last_pop, cyc;
        bit done_seen, aborted, held_v, prev_en, pop;
        logic [DATA_W-1:0] held;
        logic [ADDR_W-1:0] last_a;
        issued = 0; popped = 0; first_pop = -1; last_pop = -1;
        done_seen = 0; aborted = 0; held_v = 0; prev_en = 0; a0 = 'x; a1 = 'x; last_a = '0;
        @(negedge clk);
        start_read = 1'b1; base_addr = base; m_ready = 1'b1;
        #1;
        chk("start_no_issue", bram_en, 0);
        for (cyc = 1; cyc < 300 && !done_seen && !aborted; cyc++) begin
            @(negedge clk);
            start_read = (cyc == ign_at);
            base_addr  = (cyc == ign_at) ? 16'h0100 : base;
            m_ready    = bp ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
            #1;
            if (cyc == 1) chk("first_cycle_valid", m_valid, 0);
            if (!read_done) chk("busy_high", busy, 1);
            if (prev_en) chk("current_addr", current_addr, last_a);
            prev_en = bram_en;
            pop = m_valid && m_ready;
            if (bram_en) begin
                chk("issue_in_range", issued < TOTAL, 1);
                chk("bram_addr", bram_addr, exp_addr(base, issued));
                chk("credit", (issued - popped - int'(pop)) < DEPTH, 1);
                if (issued == 0) a0 = bram_addr;
                if (issued == 1) a1 = bram_addr;
                last_a = bram_addr;
                issued++;
            end
            if (held_v) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, held);
            end
            if (pop) begin
                chk("word", m_data, DATA_W'(exp_addr(base, popped)) + DATA_W'(2));
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                popped++;
            end
            held_v = m_valid && !m_ready;
            held   = m_data;
            if (read_done) begin
                done_seen = 1;
                chk("done_count", popped, TOTAL);
                chk("done_gap", cyc, last_pop + 2);
                chk("done_busy", busy, 0);
            end
            if (abort_after > 0 && popped == abort_after) begin
                aborted = 1;
                #1 rst_n = 1'b0;
                #1;
                chk_all_zero("abort");
                repeat (2) begin
                    @(negedge clk); #1;
                    chk("abort_no_done", read_done, 0);
                end
                @(negedge clk);
                rst_n = 1'b1; m_ready = 1'b1; start_read = 1'b0;
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("post_abort_done", read_done, 0);
                    chk("post_abort_busy", busy, 0);
                end
            end
        end
        start_read = 1'b0;
        if (!aborted) begin
            chk("done_seen", done_seen, 1);
            chk("issued_total", issued, TOTAL);
            @(negedge clk); #1;
            chk("done_pulse_one", read_done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_valid", m_valid, 0);
            if (!bp) begin
                chk("first_valid_lat", first_pop, LAT + 1);
                chk("no_bubbles", last_pop, LAT + int'(TOTAL));
            end
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a0, a1;
        rst_n = 1'b0; start_read = 1'b0; base_addr = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_tile(16'h0000, 1'b0, 0, 0, a0, a1);          // basic ordering
        chk("basic_a1", a1, 16'd24);
        run_tile(16'h0010, 1'b1, 0, 0, a0, a1);          // backpressure
        run_tile(16'hFFF0, 1'b0, 0, 0, a0, a1);          // wrap-around
        chk("wrap_a0", a0, 16'hFFF0);
        chk("wrap_a1", a1, 16'h0008);
        run_tile(16'h0200, 1'b1, 4, 0, a0, a1);          // ignored start
        run_tile(16'h0000, 1'b0, 0, 5, a0, a1);          // mid-tile reset
        run_tile(16'h0000, 1'b0, 0, 0, a0, a1);          // clean restart
        chk("restart_a0", a0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
